// File: rtl/bpu_pkg.sv
// Shared constants and helpers for the branch predictor: direction-counter
// encodings derived from the counter width.
package bpu_pkg;

  localparam int unsigned CTR_W_DEFAULT = 2;

  function automatic int unsigned ctr_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Lowest counter value whose MSB is set, i.e. the weakest "taken" state.
  function automatic int unsigned ctr_weak_t(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  function automatic int unsigned ctr_weak_nt(input int unsigned w);
    return ctr_weak_t(w) - 32'd1;
  endfunction

  localparam int unsigned CTR_MAX     = ctr_max(CTR_W_DEFAULT);
  localparam int unsigned CTR_WEAK_T  = ctr_weak_t(CTR_W_DEFAULT);
  localparam int unsigned CTR_WEAK_NT = ctr_weak_nt(CTR_W_DEFAULT);

endpackage

// File: rtl/branch_predict_unit_if.sv
// Core-to-predictor bundle: IF-stage lookup, MEM-stage training/redirect,
// and statistics. The core side is the master.
interface branch_predict_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              lookup_valid_i;
    logic              pred_hit_o;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_target_o;

    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              upd_pred_taken_i;
    logic [ADDR_W-1:0] upd_pred_target_i;
    logic              clear_i;
    logic              mispredict_o;
    logic [ADDR_W-1:0] redirect_pc_o;

    logic [CNT_W-1:0]  lookup_cnt_o;
    logic [CNT_W-1:0]  mispred_cnt_o;

    modport master (
        output pc_i, lookup_valid_i, upd_valid_i, upd_pc_i, upd_taken_i,
               upd_target_i, upd_pred_taken_i, upd_pred_target_i, clear_i,
        input  pred_hit_o, pred_taken_o, pred_target_o, mispredict_o,
               redirect_pc_o, lookup_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  pc_i, lookup_valid_i, upd_valid_i, upd_pc_i, upd_taken_i,
               upd_target_i, upd_pred_taken_i, upd_pred_target_i, clear_i,
        output pred_hit_o, pred_taken_o, pred_target_o, mispredict_o,
               redirect_pc_o, lookup_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous load; used for the per-entry
// direction counters and, increment-only, for the statistics counters.
module sat_counter #(
    parameter int unsigned           WIDTH = 2,
    parameter logic [WIDTH-1:0]      INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] MAX = '1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            count <= INIT;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !dec && count != MAX) begin
            count <= count + WIDTH'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry saturating direction counters: zero-latency
// lookup for IF, training and mispredict/redirect generation for MEM.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    branch_predict_unit_if.slave bus
);
    localparam int unsigned       IDX_W   = $clog2(ENTRIES);
    localparam int unsigned       TAG_W   = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0]  WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));
    localparam logic [CTR_W-1:0]  WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } entry_t;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    entry_t           lk_entry;
    logic             lk_hit, lk_taken, up_hit, write_we;
    logic             unused_pc_bits;

    assign lk_idx = bus.pc_i[IDX_W+1:2];
    assign lk_tag = bus.pc_i[ADDR_W-1:IDX_W+2];
    assign up_idx = bus.upd_pc_i[IDX_W+1:2];
    assign up_tag = bus.upd_pc_i[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{bus.pc_i[1:0], bus.upd_pc_i[1:0]};

    // Lookup reads registered state only, so a same-cycle update stays invisible.
    always_comb begin
        lk_entry = '{valid:  valid_q[lk_idx],
                     tag:    tag_q[lk_idx],
                     target: target_q[lk_idx],
                     ctr:    ctr_q[lk_idx]};
    end

    assign lk_hit            = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign lk_taken          = lk_hit && lk_entry.ctr[CTR_W-1];
    assign bus.pred_hit_o    = lk_hit;
    assign bus.pred_taken_o  = lk_taken;
    assign bus.pred_target_o = lk_taken ? lk_entry.target : bus.pc_i + PC_STEP;

    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    // Any taken resolution either refreshes the target or (re)allocates the slot.
    assign write_we = rst_n && bus.upd_valid_i && bus.upd_taken_i && !bus.clear_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n || bus.clear_i) begin
            valid_q <= '0;
        end else if (write_we) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target storage is not reset; the valid bits alone decide
    // whether an entry can hit, so clearing the payload buys nothing.
    always_ff @(posedge clk_i) begin
        if (write_we) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bus.upd_target_i;
        end
    end

    for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
        logic sel;
        assign sel = bus.upd_valid_i && (up_idx == IDX_W'(e));

        // Clear wins over training through the counter's load priority.
        sat_counter #(.WIDTH(CTR_W), .INIT(WEAK_NT)) u_dir (
            .clk_i    (clk_i),
            .rst_n    (rst_n),
            .inc      (sel && up_hit && bus.upd_taken_i),
            .dec      (sel && up_hit && !bus.upd_taken_i),
            .load     (bus.clear_i || (sel && !up_hit && bus.upd_taken_i)),
            .load_val (bus.clear_i ? WEAK_NT : WEAK_T),
            .count    (ctr_q[e])
        );
    end

    assign bus.mispredict_o = bus.upd_valid_i &&
        ((bus.upd_taken_i != bus.upd_pred_taken_i) ||
         (bus.upd_taken_i && (bus.upd_pred_target_i != bus.upd_target_i)));
    assign bus.redirect_pc_o = bus.upd_taken_i ? bus.upd_target_i
                                               : bus.upd_pc_i + PC_STEP;

    sat_counter #(.WIDTH(CNT_W), .INIT('0)) u_lookup_cnt (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .inc      (bus.lookup_valid_i),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .count    (bus.lookup_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W), .INIT('0)) u_mispred_cnt (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .inc      (bus.mispredict_o),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .count    (bus.mispred_cnt_o)
    );
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (16 entries, 2-bit counters, 4-bit
// statistics so saturation is reachable in a few cycles).
module tb_branch_predict_unit;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CTR_W   = 2;
    localparam int unsigned CNT_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    branch_predict_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    branch_predict_unit #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .CTR_W   (CTR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Inputs change just after a falling edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid_i = 1'b0;
        bus.clear_i     = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic taken,
                           input logic [31:0] target, input logic pt,
                           input logic [31:0] ptgt);
        bus.upd_valid_i       = 1'b1;
        bus.upd_pc_i          = pc;
        bus.upd_taken_i       = taken;
        bus.upd_target_i      = target;
        bus.upd_pred_taken_i  = pt;
        bus.upd_pred_target_i = ptgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        bus.pc_i = 32'h40;
        #1;
        tests_run++;
        if (bus.pred_hit_o !== 1'b0) begin tests_failed++; $display("FAIL reset_hit got %0b want 0", bus.pred_hit_o); end
        tests_run++;
        if (bus.pred_taken_o !== 1'b0) begin tests_failed++; $display("FAIL reset_taken got %0b want 0", bus.pred_taken_o); end
        tests_run++;
        if (bus.pred_target_o !== 32'h44) begin tests_failed++; $display("FAIL reset_target got %h want 00000044", bus.pred_target_o); end
        tests_run++;
        if (bus.lookup_cnt_o !== 4'd0 || bus.mispred_cnt_o !== 4'd0) begin tests_failed++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.lookup_cnt_o, bus.mispred_cnt_o); end
    endtask

    task automatic test_allocate();
        bus.pc_i = 32'h100;
        set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        #1;
        tests_run++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h200) begin tests_failed++; $display("FAIL alloc_mispredict got %0b/%h want 1/00000200", bus.mispredict_o, bus.redirect_pc_o); end
        tests_run++;
        if (bus.pred_hit_o !== 1'b0) begin tests_failed++; $display("FAIL alloc_pre_hit got %0b want 0", bus.pred_hit_o); end
        tick();
        #1;
        tests_run++;
        if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== {2'b11, 32'h200}) begin tests_failed++; $display("FAIL alloc_lookup got %0b%0b/%h want 11/00000200", bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o); end
        tests_run++;
        if (bus.mispred_cnt_o !== 4'd1) begin tests_failed++; $display("FAIL alloc_mispred_cnt got %0d want 1", bus.mispred_cnt_o); end
    endtask

    task automatic test_training();
        // Counter 10 -> 11 -> saturate -> saturate.
        for (int i = 0; i < 3; i++) begin
            set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
            #1;
            tests_run++;
            if (bus.mispredict_o !== 1'b0) begin tests_failed++; $display("FAIL train_taken_%0d got mispredict %0b want 0", i, bus.mispredict_o); end
            tick();
        end
        set_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        #1;
        tests_run++;
        if (bus.mispredict_o !== 1'b1 || bus.redirect_pc_o !== 32'h104) begin tests_failed++; $display("FAIL train_nt1_redirect got %0b/%h want 1/00000104", bus.mispredict_o, bus.redirect_pc_o); end
        tick();
        #1;
        tests_run++;
        if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== {2'b11, 32'h200}) begin tests_failed++; $display("FAIL train_ctr10 got %0b%0b/%h want 11/00000200", bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o); end
        set_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        tick();
        #1;
        tests_run++;
        if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== {2'b10, 32'h104}) begin tests_failed++; $display("FAIL train_ctr01 got %0b%0b/%h want 10/00000104", bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o); end
        // Retrain to weakly taken for the aliasing scenario.
        set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        tick();
    endtask

    task automatic test_aliasing();
        set_upd(32'h140, 1'b0, 32'h300, 1'b0, 32'h144);
        #1;
        tests_run++;
        if (bus.mispredict_o !== 1'b0 || bus.redirect_pc_o !== 32'h144) begin tests_failed++; $display("FAIL alias_nt_redirect got %0b/%h want 0/00000144", bus.mispredict_o, bus.redirect_pc_o); end
        tick();
        bus.pc_i = 32'h100;
        #1;
        tests_run++;
        if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== {2'b11, 32'h200}) begin tests_failed++; $display("FAIL alias_nt_keep got %0b%0b/%h want 11/00000200", bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o); end
        set_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
        tick();
        #1;
        tests_run++;
        if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== {2'b00, 32'h104}) begin tests_failed++; $display("FAIL alias_evict got %0b%0b/%h want 00/00000104", bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o); end
        bus.pc_i = 32'h140;
        #1;
        tests_run++;
        if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== {2'b11, 32'h300}) begin tests_failed++; $display("FAIL alias_new got %0b%0b/%h want 11/00000300", bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o); end
    endtask

    task automatic test_same_cycle();
        bus.pc_i = 32'h180;
        set_upd(32'h180, 1'b1, 32'h400, 1'b0, 32'h184);
        #1;
        tests_run++;
        if (bus.pred_hit_o !== 1'b0 || bus.pred_target_o !== 32'h184) begin tests_failed++; $display("FAIL same_cycle_pre got %0b/%h want 0/00000184", bus.pred_hit_o, bus.pred_target_o); end
        tick();
        #1;
        tests_run++;
        if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== {2'b11, 32'h400}) begin tests_failed++; $display("FAIL same_cycle_post got %0b%0b/%h want 11/00000400", bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o); end
    endtask

    task automatic test_clear_and_stats();
        bus.lookup_valid_i = 1'b1;
        repeat (3) tick();
        bus.lookup_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.lookup_cnt_o !== 4'd3) begin tests_failed++; $display("FAIL lookup_cnt_3 got %0d want 3", bus.lookup_cnt_o); end
        // Clear must beat a same-cycle allocating update.
        bus.clear_i = 1'b1;
        set_upd(32'h100, 1'b1, 32'h500, 1'b0, 32'h104);
        tick();
        bus.pc_i = 32'h100;
        #1;
        tests_run++;
        if (bus.pred_hit_o !== 1'b0 || bus.pred_target_o !== 32'h104) begin tests_failed++; $display("FAIL clear_miss got %0b/%h want 0/00000104", bus.pred_hit_o, bus.pred_target_o); end
        bus.pc_i = 32'h180;
        #1;
        tests_run++;
        if (bus.pred_hit_o !== 1'b0) begin tests_failed++; $display("FAIL clear_miss_180 got %0b want 0", bus.pred_hit_o); end
        tests_run++;
        if (bus.lookup_cnt_o !== 4'd3 || bus.mispred_cnt_o !== 4'd7) begin tests_failed++; $display("FAIL clear_keeps_stats got %0d/%0d want 3/7", bus.lookup_cnt_o, bus.mispred_cnt_o); end
        bus.lookup_valid_i = 1'b1;
        repeat (20) tick();
        bus.lookup_valid_i = 1'b0;
        #1;
        tests_run++;
        if (bus.lookup_cnt_o !== 4'd15) begin tests_failed++; $display("FAIL lookup_cnt_sat got %0d want 15", bus.lookup_cnt_o); end
    endtask

    task automatic test_reset_mid();
        set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        tick();
        // Reset in the same cycle as another allocating update.
        rst_n = 1'b0;
        set_upd(32'h180, 1'b1, 32'h400, 1'b0, 32'h184);
        tick();
        rst_n = 1'b1;
        bus.pc_i = 32'h100;
        #1;
        tests_run++;
        if ({bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o} !== {2'b00, 32'h104}) begin tests_failed++; $display("FAIL midreset_100 got %0b%0b/%h want 00/00000104", bus.pred_hit_o, bus.pred_taken_o, bus.pred_target_o); end
        bus.pc_i = 32'h180;
        #1;
        tests_run++;
        if (bus.pred_hit_o !== 1'b0) begin tests_failed++; $display("FAIL midreset_180 got %0b want 0", bus.pred_hit_o); end
        tests_run++;
        if (bus.lookup_cnt_o !== 4'd0 || bus.mispred_cnt_o !== 4'd0) begin tests_failed++; $display("FAIL midreset_counts got %0d/%0d want 0/0", bus.lookup_cnt_o, bus.mispred_cnt_o); end
    endtask

    initial begin
        bus.pc_i              = '0;
        bus.lookup_valid_i    = 1'b0;
        bus.upd_valid_i       = 1'b0;
        bus.upd_pc_i          = '0;
        bus.upd_taken_i       = 1'b0;
        bus.upd_target_i      = '0;
        bus.upd_pred_taken_i  = 1'b0;
        bus.upd_pred_target_i = '0;
        bus.clear_i           = 1'b0;
        @(negedge clk);
        test_reset();
        test_allocate();
        test_training();
        test_aliasing();
        test_same_cycle();
        test_clear_and_stats();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch predictor for the pipelined MIPS core: a direct-mapped branch target buffer (BTB) with per-entry N-bit saturating direction counters. The IF stage queries it combinationally every cycle to choose the next PC. The MEM stage, where branches and jumps resolve, trains it and receives a mispredict/redirect decision. This replaces the always-not-taken policy and its unconditional three-stage flush on every taken branch.

## Interface
Parameters:
- ENTRIES, 16, BTB depth; power of two, ≥2; IDX_W = log2(ENTRIES)
- ADDR_W, 32, PC width
- CTR_W, 2, direction counter width; ≥1
- CNT_W, 32, statistics counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- pc_i  in  ADDR_W  IF-stage PC to predict
- lookup_valid_i  in  1  counts a lookup when high (low while PC is stalled)
- pred_hit_o  out  1  valid entry with matching tag at pc_i
- pred_taken_o  out  1  predicted taken
- pred_target_o  out  ADDR_W  predicted next PC
- upd_valid_i  in  1  resolved control-flow instruction in MEM
- upd_pc_i  in  ADDR_W  PC of resolved instruction
- upd_taken_i  in  1  actual direction (jumps: 1)
- upd_target_i  in  ADDR_W  actual taken target
- upd_pred_taken_i  in  1  prediction carried down the pipe
- upd_pred_target_i  in  ADDR_W  predicted target carried down the pipe
- clear_i  in  1  synchronous invalidate of all entries
- mispredict_o  out  1  flush IF/ID, ID/EX, EX/MEM this cycle
- redirect_pc_o  out  ADDR_W  correct next PC when mispredict_o
- lookup_cnt_o  out  CNT_W  counted lookups, saturating
- mispred_cnt_o  out  CNT_W  mispredicts, saturating

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Entry state: valid, tag, target, ctr[CTR_W-1:0].
- Lookup, combinational:
  - pred_hit_o = valid & tag match.
  - pred_taken_o = pred_hit_o & ctr[CTR_W-1].
  - pred_target_o = entry target if pred_taken_o, else pc_i+4 (mod 2^ADDR_W).
- Update, on edge with upd_valid_i:
  - Hit, taken: ctr increments, saturating at 2^CTR_W-1; target ← upd_target_i.
  - Hit, not taken: ctr decrements, saturating at 0; target kept.
  - Miss, taken: allocate/replace. valid←1, tag, target←upd_target_i, ctr←2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no state change; an aliased entry is untouched.
- mispredict_o = upd_valid_i & ((upd_taken_i ≠ upd_pred_taken_i) | (upd_taken_i & upd_pred_target_i ≠ upd_target_i)).
- redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4.
- Stats increment by 1 and saturate at 2^CTR_W... no: at 2^CNT_W-1.
  - lookup_cnt_o increments on lookup_valid_i.
  - mispred_cnt_o increments on mispredict_o.
- clear_i invalidates all entries and resets ctrs to 2^(CTR_W-1)-1. Stats are kept.
- clear_i has priority over a same-cycle update.

## Timing
- Lookup latency 0 cycles. Update visible to a lookup in the next cycle.
- Same-cycle lookup and update to the same index: lookup returns pre-update state.
- mispredict_o and redirect_pc_o are combinational from upd_* inputs, same cycle.
- Reset (rst_n low at an edge, including mid-operation):
  - all valid←0; ctr←2^(CTR_W-1)-1; both stats←0.
  - Outputs: pred_hit_o=0, pred_taken_o=0, pred_target_o=pc_i+4.
  - mispredict_o still follows inputs; the core holds upd_valid_i low during reset.
- Reset overrides clear_i and updates.

## Structure
- Package bpu_pkg: CTR_W-derived constants CTR_MAX, CTR_WEAK_T, CTR_WEAK_NT. Entry struct typedef (valid, tag, target, ctr) as a parametrised-width helper.
- One sub-module: sat_counter (WIDTH, inc/dec/load inputs, saturating), instantiated per entry for direction.
- Stats use an increment-only saturating variant or a local always block.

## Test plan
(ENTRIES=16, CTR_W=2)
- Reset, then lookup pc_i=0x40 → hit 0, taken 0, target 0x44; both counts 0.
- Update pc 0x100, taken, target 0x200, pred_taken 0 → mispredict 1, redirect 0x200. Next cycle lookup 0x100 → hit 1, taken 1, target 0x200 (ctr 10).
- Three taken updates at 0x100 → ctr 11. One not-taken → 10, still predicts taken, mispredict 1, redirect 0x104. Second not-taken → 01, predicts not taken, target 0x104.
- Aliasing, with 0x100 trained taken:
  - not-taken update on 0x140 (same index, different tag) → 0x100 still hit/taken.
  - taken update on 0x140 target 0x300 → 0x100 now misses.
- Same-cycle lookup and update on 0x180: lookup shows miss; following cycle shows hit.
- clear_i, then lookup 0x100 → miss with lookup_cnt_o preserved. With CNT_W=4, 20 lookups → lookup_cnt_o holds 15.
